tdm_demux8: RTL



---
 rtl/tdm_demux8.sv | 94 +++++++++
 1 files changed

// File: rtl/tdm_demux8.sv
// 8-channel TDM demultiplexer: rebuilds parallel frames from a serial bit stream,
// aligning channel 0 on the sync marker and flagging framing violations.
module tdm_demux8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Y,
    input  logic       y_valid,
    input  logic       sync,
    output logic [2:0] Sel,
    output logic [7:0] O,
    output logic       frame_valid,
    output logic       sync_err,
    output logic       locked
);

    localparam int unsigned NCH = 8;
    localparam int unsigned SW  = 3;
    localparam int unsigned SHW = NCH - 1;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [SHW-1:0]   shadow, shadow_d;
    logic [SW-1:0]    sel_d;
    logic [NCH-1:0]   o_d;
    logic             fv_d;
    logic             se_d;

    // State, frame assembly and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            shadow      <= '0;
            Sel         <= '0;
            O           <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_d;
            shadow      <= shadow_d;
            Sel         <= sel_d;
            O           <= o_d;
            frame_valid <= fv_d;
            sync_err    <= se_d;
            locked      <= (state_d == LOCKED);
        end
    end

    // Next-state and per-bit routing
    always_comb begin
        state_d  = state;
        shadow_d = shadow;
        sel_d    = Sel;
        o_d      = O;
        fv_d     = 1'b0;
        se_d     = 1'b0;

        if (y_valid) begin
            unique case (state)
                HUNT: begin
                    if (sync) begin
                        shadow_d[0] = Y;
                        sel_d       = SW'(1);
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // Sync always restarts at channel 0; mid-frame it also drops the partial frame
                        se_d        = (Sel != '0);
                        shadow_d[0] = Y;
                        sel_d       = SW'(1);
                    end else if (Sel == '0) begin
                        se_d    = 1'b1;
                        state_d = HUNT;
                    end else if (Sel == SW'(NCH - 1)) begin
                        o_d   = {Y, shadow};
                        fv_d  = 1'b1;
                        sel_d = '0;
                    end else begin
                        shadow_d[Sel] = Y;
                        sel_d         = Sel + SW'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

endmodule
